// File: rtl/edge_bbox_pkg.sv
// Shared types and constants for the edge bounding-box tracker.
package edge_bbox_pkg;

   localparam int COORD_W = 11;
   localparam int CNT_W   = 21;

   localparam logic [COORD_W-1:0] COORD_INIT_MIN = 11'h7FF;
   localparam logic [COORD_W-1:0] COORD_MAX      = 11'h7FF;
   localparam logic [CNT_W-1:0]   CNT_MAX        = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FRAME = 2'd1,
      S_DONE  = 2'd2
   } bbox_state_e;

endpackage

// File: rtl/edge_bbox_tracker_if.sv
// Edge-bit video stream: frame/line/pixel qualifiers plus the edge bit.
// The producer drives through master, the consumer reads through slave.
interface edge_bbox_tracker_if;

   logic img_vsync;
   logic img_href;
   logic img_clken;
   logic img_bit;

   modport master (output img_vsync, output img_href, output img_clken, output img_bit);
   modport slave  (input  img_vsync, input  img_href, input  img_clken, input  img_bit);

endinterface

// File: rtl/img_pos_counter.sv
// Frame/line edge detection and saturating pixel position counters.
// x_cnt is the column of the current qualified pixel, y_cnt its row.
module img_pos_counter
   import edge_bbox_pkg::*;
(
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               vsync,
   input  logic               href,
   input  logic               clken,
   input  logic               in_frame,
   input  logic               frame_init,
   output logic               frame_start,
   output logic               frame_end,
   output logic               pix_qual,
   output logic [COORD_W-1:0] x_cnt,
   output logic [COORD_W-1:0] y_cnt
);

   logic vsync_d;
   logic href_d;
   logic vsync_low_seen;
   logic href_fall;

   // Edge history; vsync_low_seen blocks a false start when reset releases mid-frame.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         vsync_d        <= 1'b0;
         href_d         <= 1'b0;
         vsync_low_seen <= 1'b0;
      end else begin
         vsync_d <= vsync;
         href_d  <= href;
         if (!vsync) vsync_low_seen <= 1'b1;
      end
   end

   assign frame_start = vsync & ~vsync_d & vsync_low_seen;
   assign frame_end   = ~vsync & vsync_d;
   assign href_fall   = ~href & href_d;
   assign pix_qual    = vsync & href & clken & in_frame;

   // Column counter: one step per qualified pixel, cleared at line end.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         x_cnt <= '0;
      end else if (frame_init || href_fall) begin
         x_cnt <= '0;
      end else if (pix_qual && (x_cnt != COORD_MAX)) begin
         x_cnt <= x_cnt + COORD_W'(1);
      end
   end

   // Row counter: one step per line end while a frame is being tracked.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         y_cnt <= '0;
      end else if (frame_init) begin
         y_cnt <= '0;
      end else if (href_fall && in_frame && (y_cnt != COORD_MAX)) begin
         y_cnt <= y_cnt + COORD_W'(1);
      end
   end

endmodule

// File: rtl/edge_bbox_tracker.sv
// Tracks the bounding box of edge pixels per frame and publishes it at frame end.
// Optional feature macro: EDGE_BBOX_COUNT_EN (full edge count, edge_cnt port,
// MIN_EDGE_CNT threshold for bbox_found).
//
// state   | meaning
// S_IDLE  | waiting for a vsync rising edge
// S_FRAME | accumulating edge pixels of the current frame
// S_DONE  | one cycle: publish box, then idle (or restart on an immediate rise)
module edge_bbox_tracker
   import edge_bbox_pkg::*;
#(
   parameter logic [COORD_W-1:0] IMG_HDISP = 11'd640,
   parameter logic [COORD_W-1:0] IMG_VDISP = 11'd480
`ifdef EDGE_BBOX_COUNT_EN
   , parameter logic [CNT_W-1:0] MIN_EDGE_CNT = 21'd16
`endif
)(
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   edge_bbox_tracker_if.slave        per_img,
   edge_bbox_tracker_if.master       post_img,
   output logic [COORD_W-1:0]        bbox_x_min,
   output logic [COORD_W-1:0]        bbox_x_max,
   output logic [COORD_W-1:0]        bbox_y_min,
   output logic [COORD_W-1:0]        bbox_y_max,
   output logic                      bbox_found,
   output logic                      bbox_valid
`ifdef EDGE_BBOX_COUNT_EN
   , output logic [CNT_W-1:0]        edge_cnt
`endif
);

   bbox_state_e state_q, state_d;

   logic               frame_start;
   logic               frame_end;
   logic               pix_qual;
   logic               frame_init;
   logic               latch_out;
   logic               pix_hit;
   logic               frame_found;
   logic [COORD_W-1:0] x_cnt;
   logic [COORD_W-1:0] y_cnt;
   logic [COORD_W-1:0] acc_x_min, acc_x_max, acc_y_min, acc_y_max;
`ifdef EDGE_BBOX_COUNT_EN
   logic [CNT_W-1:0]   acc_cnt;
`else
   logic               acc_any;
`endif

   img_pos_counter u_pos (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .vsync       (per_img.img_vsync),
      .href        (per_img.img_href),
      .clken       (per_img.img_clken),
      .in_frame    (state_q == S_FRAME),
      .frame_init  (frame_init),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .pix_qual    (pix_qual),
      .x_cnt       (x_cnt),
      .y_cnt       (y_cnt)
   );

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next state; a rise seen while publishing starts the next frame directly.
   always_comb begin
      state_d    = state_q;
      frame_init = 1'b0;
      latch_out  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d    = S_FRAME;
               frame_init = 1'b1;
            end
         end
         S_FRAME: begin
            if (frame_end) state_d = S_DONE;
         end
         S_DONE: begin
            latch_out = 1'b1;
            if (frame_start) begin
               state_d    = S_FRAME;
               frame_init = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pix_hit = pix_qual & per_img.img_bit & (x_cnt < IMG_HDISP) & (y_cnt < IMG_VDISP);

`ifdef EDGE_BBOX_COUNT_EN
   assign frame_found = (acc_cnt >= MIN_EDGE_CNT);
`else
   assign frame_found = acc_any;
`endif

   // Min/max accumulators over in-window edge pixels of the current frame.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         acc_x_min <= '0;
         acc_x_max <= '0;
         acc_y_min <= '0;
         acc_y_max <= '0;
`ifdef EDGE_BBOX_COUNT_EN
         acc_cnt   <= '0;
`else
         acc_any   <= 1'b0;
`endif
      end else if (frame_init) begin
         acc_x_min <= COORD_INIT_MIN;
         acc_x_max <= '0;
         acc_y_min <= COORD_INIT_MIN;
         acc_y_max <= '0;
`ifdef EDGE_BBOX_COUNT_EN
         acc_cnt   <= '0;
`else
         acc_any   <= 1'b0;
`endif
      end else if (pix_hit) begin
         if (x_cnt < acc_x_min) acc_x_min <= x_cnt;
         if (x_cnt > acc_x_max) acc_x_max <= x_cnt;
         if (y_cnt < acc_y_min) acc_y_min <= y_cnt;
         if (y_cnt > acc_y_max) acc_y_max <= y_cnt;
`ifdef EDGE_BBOX_COUNT_EN
         if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + CNT_W'(1);
`else
         acc_any <= 1'b1;
`endif
      end
   end

   // Publish the box in S_DONE; an empty frame reports an all-zero box.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         bbox_valid <= 1'b0;
         bbox_found <= 1'b0;
         bbox_x_min <= '0;
         bbox_x_max <= '0;
         bbox_y_min <= '0;
         bbox_y_max <= '0;
`ifdef EDGE_BBOX_COUNT_EN
         edge_cnt   <= '0;
`endif
      end else begin
         bbox_valid <= latch_out;
         if (latch_out) begin
            bbox_found <= frame_found;
            bbox_x_min <= frame_found ? acc_x_min : '0;
            bbox_x_max <= frame_found ? acc_x_max : '0;
            bbox_y_min <= frame_found ? acc_y_min : '0;
            bbox_y_max <= frame_found ? acc_y_max : '0;
`ifdef EDGE_BBOX_COUNT_EN
            edge_cnt   <= acc_cnt;
`endif
         end
      end
   end

   // One-cycle pass-through of the video stream, independent of the FSM.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         post_img.img_vsync <= 1'b0;
         post_img.img_href  <= 1'b0;
         post_img.img_clken <= 1'b0;
         post_img.img_bit   <= 1'b0;
      end else begin
         post_img.img_vsync <= per_img.img_vsync;
         post_img.img_href  <= per_img.img_href;
         post_img.img_clken <= per_img.img_clken;
         post_img.img_bit   <= per_img.img_bit;
      end
   end

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Self-checking bench for edge_bbox_tracker with a frame-level reference model.
// Honors EDGE_BBOX_COUNT_EN the same way the design does.
module tb_edge_bbox_tracker;

   localparam int HD   = 16;
   localparam int VD   = 8;
   localparam int MINC = 2;

   logic sys_clk = 1'b0;
   logic sys_rst;
   always #5 sys_clk = ~sys_clk;

   edge_bbox_tracker_if per_img ();
   edge_bbox_tracker_if post_img ();

   logic [10:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
   logic        bbox_found, bbox_valid;
`ifdef EDGE_BBOX_COUNT_EN
   logic [20:0] edge_cnt;
`endif

   edge_bbox_tracker #(
      .IMG_HDISP    (11'd16),
      .IMG_VDISP    (11'd8)
`ifdef EDGE_BBOX_COUNT_EN
      , .MIN_EDGE_CNT (21'd2)
`endif
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .per_img    (per_img),
      .post_img   (post_img),
      .bbox_x_min (bbox_x_min),
      .bbox_x_max (bbox_x_max),
      .bbox_y_min (bbox_y_min),
      .bbox_y_max (bbox_y_max),
      .bbox_found (bbox_found),
      .bbox_valid (bbox_valid)
`ifdef EDGE_BBOX_COUNT_EN
      , .edge_cnt (edge_cnt)
`endif
   );

   typedef struct {
      logic [10:0] x0, x1, y0, y1;
      logic        found;
      logic [20:0] cnt;
      int          t;
   } rep_t;

   int   n_chk = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   rep_t got_q[$];
   rep_t exp_q[$];
   logic emap [0:15][0:31];
   logic [3:0] in_q;
   logic pt_en = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   always @(posedge sys_clk) begin
      cyc  <= cyc + 1;
      in_q <= {per_img.img_vsync, per_img.img_href, per_img.img_clken, per_img.img_bit};
   end

   // Collect published boxes; optionally compare the pass-through stream.
   always @(negedge sys_clk) begin
      rep_t r;
      if (bbox_valid) begin
         r.x0 = bbox_x_min; r.x1 = bbox_x_max;
         r.y0 = bbox_y_min; r.y1 = bbox_y_max;
         r.found = bbox_found;
`ifdef EDGE_BBOX_COUNT_EN
         r.cnt = edge_cnt;
`else
         r.cnt = '0;
`endif
         r.t = cyc;
         got_q.push_back(r);
      end
      if (pt_en)
         chk("passthru", {post_img.img_vsync, post_img.img_href, post_img.img_clken, post_img.img_bit}, in_q);
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic clear_map();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 32; c++)
            emap[r][c] = 1'b0;
   endtask

   task automatic rand_map(input int dens);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 32; c++)
            emap[r][c] = ($urandom_range(0, 99) < dens);
   endtask

   // Bounding box of all in-window edges of the map, from plain loops.
   task automatic model(input int nl, input int ll, output rep_t e);
      int n = 0;
      int xa = 2047, xb = 0, ya = 2047, yb = 0;
      for (int r = 0; r < nl && r < VD; r++)
         for (int c = 0; c < ll && c < HD; c++)
            if (emap[r][c]) begin
               n++;
               if (c < xa) xa = c;
               if (c > xb) xb = c;
               if (r < ya) ya = r;
               if (r > yb) yb = r;
            end
`ifdef EDGE_BBOX_COUNT_EN
      e.found = (n >= MINC);
`else
      e.found = (n > 0);
`endif
      e.cnt = 21'(n);
      e.x0 = e.found ? 11'(xa) : 11'd0;
      e.x1 = e.found ? 11'(xb) : 11'd0;
      e.y0 = e.found ? 11'(ya) : 11'd0;
      e.y1 = e.found ? 11'(yb) : 11'd0;
      e.t  = 0;
   endtask

   // One frame of nl lines with ll qualified pixels each; ends with one low vsync cycle.
   task automatic drive_frame(input int nl, input int ll, input int rst_line, input int gap_pct);
      rep_t e;
      int   c;
      model(nl, ll, e);
      per_img.img_vsync = 1'b1; per_img.img_href = 1'b0;
      per_img.img_clken = 1'b1; per_img.img_bit  = 1'b0;
      idle(3);
      for (int r = 0; r < nl; r++) begin
         if (r == rst_line) begin
            sys_rst = 1'b1;
            step();
            sys_rst = 1'b0;
            chk("rst_mid_valid", bbox_valid, 0);
            chk("rst_mid_found", bbox_found, 0);
            chk("rst_mid_box", {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}, 0);
            chk("rst_mid_post", {post_img.img_vsync, post_img.img_href, post_img.img_clken, post_img.img_bit}, 0);
         end
         per_img.img_href = 1'b1;
         c = 0;
         while (c < ll) begin
            if ($urandom_range(0, 99) < gap_pct) begin
               per_img.img_clken = 1'b0;
               per_img.img_bit   = 1'($urandom);
            end else begin
               per_img.img_clken = 1'b1;
               per_img.img_bit   = emap[r][c];
               c++;
            end
            step();
         end
         per_img.img_href = 1'b0; per_img.img_clken = 1'b1; per_img.img_bit = 1'b0;
         idle(2);
      end
      per_img.img_vsync = 1'b0;
      e.t = cyc;
      if (rst_line < 0) exp_q.push_back(e);
      step();
   endtask

   task automatic expect_report(input string tag);
      rep_t g, e;
      int   w = 0;
      while (got_q.size() == 0 && w < 40) begin
         @(negedge sys_clk);
         w++;
      end
      chk({tag, "_seen"}, (got_q.size() != 0), 1);
      if (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_xmin"}, g.x0, e.x0);
         chk({tag, "_xmax"}, g.x1, e.x1);
         chk({tag, "_ymin"}, g.y0, e.y0);
         chk({tag, "_ymax"}, g.y1, e.y1);
         chk({tag, "_found"}, g.found, e.found);
`ifdef EDGE_BBOX_COUNT_EN
         chk({tag, "_cnt"}, g.cnt, e.cnt);
`endif
         chk({tag, "_lat"}, 64'(g.t - e.t), 2);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst = 1'b1;
      per_img.img_vsync = 1'b0; per_img.img_href = 1'b0;
      per_img.img_clken = 1'b1; per_img.img_bit  = 1'b0;
      idle(3);
      sys_rst = 1'b0;
      chk("rst_valid", bbox_valid, 0);
      chk("rst_found", bbox_found, 0);
      chk("rst_box", {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}, 0);
      chk("rst_post", {post_img.img_vsync, post_img.img_href, post_img.img_clken, post_img.img_bit}, 0);
`ifdef EDGE_BBOX_COUNT_EN
      chk("rst_cnt", edge_cnt, 0);
`endif
      idle(2);

      // three scattered edges
      clear_map();
      emap[2][3] = 1'b1; emap[5][10] = 1'b1; emap[1][7] = 1'b1;
      drive_frame(8, 16, -1, 0);
      expect_report("t1");
      chk("t1_xmin_lit", bbox_x_min, 3);
      chk("t1_xmax_lit", bbox_x_max, 10);
      chk("t1_ymin_lit", bbox_y_min, 1);
      chk("t1_ymax_lit", bbox_y_max, 5);
      chk("t1_found_lit", bbox_found, 1);
      idle(3);

      // empty frame
      clear_map();
      drive_frame(8, 16, -1, 0);
      expect_report("t2");
      chk("t2_found_lit", bbox_found, 0);
      idle(3);

      // single edge at the origin
      clear_map();
      emap[0][0] = 1'b1;
      drive_frame(8, 16, -1, 0);
      expect_report("t3");
`ifdef EDGE_BBOX_COUNT_EN
      chk("t3_found_lit", bbox_found, 0);
`else
      chk("t3_found_lit", bbox_found, 1);
`endif
      idle(3);

      // wide lines and extra rows: out-of-window edges ignored
      clear_map();
      emap[3][17] = 1'b1; emap[3][4] = 1'b1; emap[5][4] = 1'b1; emap[5][17] = 1'b1;
      emap[9][4] = 1'b1; emap[9][12] = 1'b1;
      drive_frame(10, 20, -1, 0);
      expect_report("t4");
      chk("t4_xmin_lit", bbox_x_min, 4);
      chk("t4_xmax_lit", bbox_x_max, 4);
      idle(3);

      // reset in line 4 discards the frame; the next frame reports
      rand_map(20);
      drive_frame(8, 16, 4, 0);
      idle(8);
      chk("t5_no_report", got_q.size(), 0);
      rand_map(20);
      drive_frame(8, 16, -1, 0);
      expect_report("t5_next");
      idle(3);

      // back-to-back frames with a single low vsync cycle
      pt_en = 1'b1;
      rand_map(15);
      drive_frame(8, 16, -1, 15);
      rand_map(30);
      drive_frame(8, 16, -1, 15);
      idle(2);
      pt_en = 1'b0;
      expect_report("t6_a");
      expect_report("t6_b");
      idle(2);

      // random frames
      for (int k = 0; k < 8; k++) begin
         rand_map($urandom_range(0, 40));
         drive_frame($urandom_range(1, 10), $urandom_range(1, 20), -1, $urandom_range(0, 30));
         expect_report($sformatf("rnd%0d", k));
         idle($urandom_range(0, 4));
      end

      idle(6);
      chk("extra_reports", got_q.size(), 0);
      chk("unmatched_expect", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
